gshare_predictor: RTL
=====================

# gshare_predictor

Parametrised gshare direction predictor for the IF1 stage. It replaces the fixed 4-bit PHT with configurable history, index and counter widths. It owns the speculative global history register and repairs it on EX-stage mispredicts. A post-reset sweep FSM initialises the pattern table, so the array needs no reset. IF1 reads the prediction combinationally; EX writes the resolved outcome back one branch per cycle.

## Interface
- GHR_WIDTH, 8, global history length in bits (1..IDX_WIDTH)
- IDX_WIDTH, 8, PHT index width; table depth is 2^IDX_WIDTH
- CTR_WIDTH, 2, saturating counter width (2..4)
- PC_LSB, 2, lowest PC bit used for indexing

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ready  out  1  high once the table sweep completes
- pred_valid  in  1  IF1 holds a branch needing a prediction this cycle
- if1_pc  in  32  IF1 PC
- pred_taken  out  1  predicted direction (combinational)
- pred_ghr  out  GHR_WIDTH  history snapshot used for this lookup; travels with the branch
- upd_valid  in  1  EX resolves a conditional branch this cycle
- ex_pc  in  32  resolved branch PC
- upd_ghr  in  GHR_WIDTH  snapshot that branch carried from IF1
- upd_taken  in  1  actual direction
- upd_mispredict  in  1  predicted direction was wrong

## Operation
- Index hash: idx = pc[PC_LSB+IDX_WIDTH-1:PC_LSB] XOR zero-extended ghr. Lookup uses spec_ghr; update uses upd_ghr.
- Constants:
  - CTR_INIT = 2^(CTR_WIDTH-1)-1 (weakly not-taken).
  - CTR_MAX = 2^CTR_WIDTH-1.
- Prediction: pred_taken = MSB of PHT[idx] when state==RUN, otherwise 0. pred_ghr = spec_ghr.
- Counter update on upd_valid in RUN:
  - taken: +1, saturating at CTR_MAX.
  - not-taken: −1, saturating at 0.
- FSM states:
  - INIT: init_ptr walks from 0 to 2^IDX_WIDTH−1, writing CTR_INIT to one entry per cycle. Moves to RUN after the last write.
  - RUN: normal operation. There is no path back to INIT except rst.
- spec_ghr next-state, in priority order (RUN only):
  1. upd_valid && upd_mispredict: {upd_ghr[GHR_WIDTH-2:0], upd_taken} (repair). A same-cycle pred_valid shift is discarded, because IF1 is being flushed.
  2. pred_valid: {spec_ghr[GHR_WIDTH-2:0], pred_taken}.
  3. Otherwise: hold.
- For GHR_WIDTH==1 the shift degenerates to a plain load of the new bit.
- In INIT, pred_valid and upd_valid are ignored: no table write and no GHR change.
- Same-entry read and write in one cycle: the read returns the old value, and the write lands at the edge. There is no bypass.

## Timing
- Reset values:
  - state=INIT, init_ptr=0, spec_ghr=0.
  - ready=0, pred_taken=0, pred_ghr=0.
  - PHT contents are undefined until the sweep ends.
- ready rises exactly 2^IDX_WIDTH rising edges after rst deasserts, and then stays high.
- rst asserted mid-sweep or mid-run immediately restores the reset values. The sweep restarts from 0.
- Prediction latency is 0 cycles (same-cycle combinational). History and counter updates are visible on the cycle after the edge.
- Throughput is one prediction and one update per cycle, simultaneously.

## Structure
- Package bp_pkg:
  - CTR_INIT/CTR_MAX derivation
  - the hash function
  - the saturating-counter next-value function
  - the FSM state enum (INIT, RUN)
- Sub-module gshare_pht_ram: 2^IDX_WIDTH × CTR_WIDTH array.
  - One asynchronous read port, one synchronous write port.
  - Write mux between sweep port and update port lives in the parent.
- The parent holds the FSM, init_ptr, spec_ghr and update logic.

## Test plan
- Reset then idle (defaults): ready=0 for 256 cycles and 1 on cycle 256; the first lookup of every index gives pred_taken=0.
- Train: upd_valid, ex_pc=0x100, upd_ghr=0, taken ×2. Then a lookup at if1_pc=0x100 with spec_ghr=0 gives pred_taken=1. Three further taken updates keep the counter at 3. Four not-taken updates bring it to 0, one at a time.
- GHR shift: from spec_ghr=0x00, three pred_valid cycles predicting 1, 0, 1 leave pred_ghr=0x05.
- Repair collision: same cycle pred_valid=1 and upd_valid+upd_mispredict with upd_ghr=0x3C, upd_taken=1. Next cycle spec_ghr=0x79 and the prediction shift is lost.
- Aliasing hash: pc 0x104 with ghr 0x01 and pc 0x100 with ghr 0x00 map to the same index, so training one changes the other's prediction.
- Mid-sweep reset: pulse rst at cycle 100 of INIT. ready stays 0 for a full 256 cycles after release, and upd_valid during INIT leaves no trace.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the gshare direction predictor: FSM states, counter
// constants, the index hash and the saturating-counter step.
package bp_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    // Counters are at most 4 bits wide, so helpers work on a 4-bit container.
    function automatic logic [3:0] ctr_max(input int unsigned ctr_width);
        return 4'((32'd1 << ctr_width) - 32'd1);
    endfunction

    function automatic logic [3:0] ctr_init(input int unsigned ctr_width);
        return 4'((32'd1 << (ctr_width - 1)) - 32'd1);
    endfunction

    function automatic logic [3:0] ctr_next(
        input logic [3:0]  ctr,
        input logic        taken,
        input int unsigned ctr_width
    );
        logic [3:0] max_val;
        max_val = ctr_max(ctr_width);
        if (taken) begin
            return (ctr == max_val) ? ctr : ctr + 4'd1;
        end
        return (ctr == 4'd0) ? ctr : ctr - 4'd1;
    endfunction

    // PC slice XOR zero-extended history; caller truncates to its index width.
    function automatic logic [31:0] gshare_hash(
        input logic [31:0] pc,
        input logic [31:0] ghr,
        input int unsigned pc_lsb,
        input int unsigned idx_width
    );
        logic [31:0] mask;
        mask = (32'd1 << idx_width) - 32'd1;
        return ((pc >> pc_lsb) ^ ghr) & mask;
    endfunction

endpackage

// File: rtl/gshare_pht_ram.sv
// Pattern history table storage: asynchronous read, synchronous write.
// No reset; the parent sweeps every entry after reset.
module gshare_pht_ram #(
    parameter int unsigned IDX_WIDTH = 8,
    parameter int unsigned CTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [IDX_WIDTH-1:0] wr_addr,
    input  logic [CTR_WIDTH-1:0] wr_data,
    input  logic [IDX_WIDTH-1:0] rd_addr,
    output logic [CTR_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << IDX_WIDTH;

    logic [CTR_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: combinational IF1 lookup, EX-stage counter update,
// speculative global history with mispredict repair, post-reset table sweep.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned GHR_WIDTH = 8,
    parameter int unsigned IDX_WIDTH = 8,
    parameter int unsigned CTR_WIDTH = 2,
    parameter int unsigned PC_LSB    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ready,
    input  logic                 pred_valid,
    input  logic [31:0]          if1_pc,
    output logic                 pred_taken,
    output logic [GHR_WIDTH-1:0] pred_ghr,
    input  logic                 upd_valid,
    input  logic [31:0]          ex_pc,
    input  logic [GHR_WIDTH-1:0] upd_ghr,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict
);

    localparam logic [CTR_WIDTH-1:0] CTR_INIT_V = CTR_WIDTH'(ctr_init(CTR_WIDTH));

    bp_state_e            state_q, state_d;
    logic [IDX_WIDTH-1:0] init_ptr_q, init_ptr_d;
    logic [GHR_WIDTH-1:0] spec_ghr_q, spec_ghr_d;

    logic [IDX_WIDTH-1:0] lookup_idx;
    logic [IDX_WIDTH-1:0] update_idx;
    logic [CTR_WIDTH-1:0] pred_ctr;
    logic [CTR_WIDTH-1:0] upd_ctr;
    logic [CTR_WIDTH-1:0] upd_ctr_next;
    logic [GHR_WIDTH-1:0] shift_ghr;
    logic [GHR_WIDTH-1:0] repair_ghr;

    logic                 wr_en;
    logic [IDX_WIDTH-1:0] wr_addr;
    logic [CTR_WIDTH-1:0] wr_data;

    logic [IDX_WIDTH-1:0] bank_rd_addr [2];
    logic [CTR_WIDTH-1:0] bank_rd_data [2];

    assign lookup_idx = IDX_WIDTH'(gshare_hash(if1_pc, 32'(spec_ghr_q), PC_LSB, IDX_WIDTH));
    assign update_idx = IDX_WIDTH'(gshare_hash(ex_pc, 32'(upd_ghr), PC_LSB, IDX_WIDTH));

    // Two identical copies, written together, so lookup and update each get
    // their own single read port in the same cycle.
    assign bank_rd_addr[0] = lookup_idx;
    assign bank_rd_addr[1] = update_idx;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            gshare_pht_ram #(
                .IDX_WIDTH(IDX_WIDTH),
                .CTR_WIDTH(CTR_WIDTH)
            ) u_pht (
                .clk    (clk),
                .wr_en  (wr_en),
                .wr_addr(wr_addr),
                .wr_data(wr_data),
                .rd_addr(bank_rd_addr[gi]),
                .rd_data(bank_rd_data[gi])
            );
        end
    endgenerate

    assign pred_ctr     = bank_rd_data[0];
    assign upd_ctr      = bank_rd_data[1];
    assign upd_ctr_next = CTR_WIDTH'(ctr_next(4'(upd_ctr), upd_taken, CTR_WIDTH));

    // Counter MSB set is the same as counter above the weakly-not-taken value.
    assign pred_taken = (state_q == ST_RUN) && (pred_ctr > CTR_INIT_V);
    assign pred_ghr   = spec_ghr_q;
    assign ready      = (state_q == ST_RUN);

    generate
        if (GHR_WIDTH == 1) begin : g_ghr_bit
            assign shift_ghr  = pred_taken;
            assign repair_ghr = upd_taken;
        end else begin : g_ghr_shift
            assign shift_ghr  = {spec_ghr_q[GHR_WIDTH-2:0], pred_taken};
            assign repair_ghr = {upd_ghr[GHR_WIDTH-2:0], upd_taken};
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        spec_ghr_d = spec_ghr_q;
        wr_en      = 1'b0;
        wr_addr    = init_ptr_q;
        wr_data    = CTR_INIT_V;
        case (state_q)
            ST_INIT: begin
                wr_en   = 1'b1;
                wr_addr = init_ptr_q;
                wr_data = CTR_INIT_V;
                if (init_ptr_q == {IDX_WIDTH{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    init_ptr_d = init_ptr_q + IDX_WIDTH'(1);
                end
            end
            ST_RUN: begin
                if (upd_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = update_idx;
                    wr_data = upd_ctr_next;
                end
                // Repair wins: a same-cycle IF1 shift belongs to a flushed path.
                if (upd_valid && upd_mispredict) begin
                    spec_ghr_d = repair_ghr;
                end else if (pred_valid) begin
                    spec_ghr_d = shift_ghr;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            spec_ghr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            spec_ghr_q <= spec_ghr_d;
        end
    end

endmodule
